// File: rtl/shapool_pkg.sv
// shapool_pkg: shared state encoding and sizing helpers for the shapool job sequencer
package shapool_pkg;
  typedef enum logic [2:0] {IDLE, ARMED, LAUNCH, WAIT, DONE} state_t;
  function automatic int pool_log2(input int n);
    return $clog2(n);
  endfunction
  function automatic int wdog_width(input int t);
    return $clog2(t + 1);
  endfunction
endpackage

// File: rtl/shapool_watchdog.sv
// shapool_watchdog: per-pass down-counter that flags the cycle in which it reaches zero
module shapool_watchdog #(
  parameter int WIDTH = 8,
  parameter int LOAD_VALUE = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);
  logic [WIDTH-1:0] count;
  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else if (load) count <= WIDTH'(LOAD_VALUE);
    else if (enable && count != '0) count <= count - 1'b1;
  end
  // high on the edge that takes the count from 1 to 0
  assign expired = enable && count == WIDTH'(1);
endmodule

// File: rtl/shapool_controller.sv
// shapool_controller: sequences nonce-block hashing passes across the core pool and holds the result
module shapool_controller
  import shapool_pkg::*;
#(
  parameter int NONCE_WIDTH = 32,
  parameter int POOL_N = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_load,
  input  logic [NONCE_WIDTH-1:0] cfg_base_nonce,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   result_ack,
  input  logic                   core_done,
  input  logic [POOL_N-1:0]      core_match_flags,
  output logic                   core_reset_n,
  output logic                   core_start,
  output logic [NONCE_WIDTH-1:0] core_nonce_base,
  output logic [NONCE_WIDTH-1:0] result_nonce,
  output logic [POOL_N-1:0]      result_flags,
  output logic                   success,
  output logic                   exhausted,
  output logic                   timeout,
  output logic                   ready
);
  localparam int POOL_LOG2 = pool_log2(POOL_N);
  localparam int WDOG_W = wdog_width(TIMEOUT_CYCLES);
  state_t state;
  logic expired;
  logic hit;
  logic last_block;
  logic [NONCE_WIDTH-1:0] aligned_base;
  assign hit = |core_match_flags;
  assign last_block = &core_nonce_base[NONCE_WIDTH-1:POOL_LOG2];
  assign aligned_base = cfg_base_nonce & ~NONCE_WIDTH'(POOL_N - 1);
  shapool_watchdog #(.WIDTH(WDOG_W), .LOAD_VALUE(TIMEOUT_CYCLES)) u_watchdog (
    .clk(clk),
    .reset(reset),
    .load(state == LAUNCH),
    .enable(state == WAIT),
    .expired(expired)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      core_reset_n <= 1'b0;
      core_start <= 1'b0;
      core_nonce_base <= '0;
      result_nonce <= '0;
      result_flags <= '0;
      success <= 1'b0;
      exhausted <= 1'b0;
      timeout <= 1'b0;
      ready <= 1'b0;
    end else begin
      core_start <= 1'b0;
      case (state)
        IDLE: if (cfg_load) begin
          core_nonce_base <= aligned_base;
          state <= ARMED;
        end
        ARMED: if (abort) begin
          state <= IDLE;
        end else if (start) begin
          core_reset_n <= 1'b1;
          state <= LAUNCH;
        end else if (cfg_load) begin
          core_nonce_base <= aligned_base;
        end
        LAUNCH: if (abort) begin
          core_reset_n <= 1'b0;
          state <= IDLE;
        end else begin
          core_start <= 1'b1;
          state <= WAIT;
        end
        WAIT: if (abort) begin
          core_reset_n <= 1'b0;
          state <= IDLE;
        end else if (core_done && !hit && !last_block) begin
          core_nonce_base <= core_nonce_base + NONCE_WIDTH'(POOL_N);
          state <= LAUNCH;
        end else if (core_done || expired) begin
          // a late core_done still beats the watchdog in its expiry cycle
          success <= core_done && hit;
          exhausted <= core_done && !hit;
          timeout <= !core_done;
          result_flags <= core_done ? core_match_flags : '0;
          result_nonce <= core_nonce_base;
          ready <= 1'b1;
          core_reset_n <= 1'b0;
          state <= DONE;
        end
        DONE: if (result_ack) begin
          ready <= 1'b0;
          success <= 1'b0;
          exhausted <= 1'b0;
          timeout <= 1'b0;
          result_flags <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shapool_controller.sv
// tb_shapool_controller: scoreboard bench checking pass bases and job results against expectations
module tb_shapool_controller;
  typedef struct {
    logic [7:0] nonce;
    logic [3:0] flags;
    logic       s;
    logic       e;
    logic       t;
  } res_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cfg_load = 1'b0;
  logic [7:0] cfg_base_nonce = '0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic result_ack = 1'b0;
  logic core_done = 1'b0;
  logic [3:0] core_match_flags = '0;
  logic core_reset_n;
  logic core_start;
  logic [7:0] core_nonce_base;
  logic [7:0] result_nonce;
  logic [3:0] result_flags;
  logic success;
  logic exhausted;
  logic timeout;
  logic ready;
  logic ready_q = 1'b0;
  int checks = 0;
  int errors = 0;
  int n;
  logic [7:0] pass_q[$];
  res_t res_q[$];
  logic [7:0] exp_base;
  res_t exp_res;
  shapool_controller #(.NONCE_WIDTH(8), .POOL_N(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk),
    .reset(reset),
    .cfg_load(cfg_load),
    .cfg_base_nonce(cfg_base_nonce),
    .start(start),
    .abort(abort),
    .result_ack(result_ack),
    .core_done(core_done),
    .core_match_flags(core_match_flags),
    .core_reset_n(core_reset_n),
    .core_start(core_start),
    .core_nonce_base(core_nonce_base),
    .result_nonce(result_nonce),
    .result_flags(result_flags),
    .success(success),
    .exhausted(exhausted),
    .timeout(timeout),
    .ready(ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!reset && core_start === 1'b1) begin
      if (pass_q.size() == 0) chk("unexpected_core_start", 1, 0);
      else begin
        exp_base = pass_q.pop_front();
        chk("pass_base", core_nonce_base, exp_base);
        chk("pass_core_reset_n", core_reset_n, 1);
      end
    end
    if (!reset && ready === 1'b1 && ready_q !== 1'b1) begin
      if (res_q.size() == 0) chk("unexpected_ready", 1, 0);
      else begin
        exp_res = res_q.pop_front();
        chk("result_nonce", result_nonce, exp_res.nonce);
        chk("result_flags", result_flags, exp_res.flags);
        chk("success", success, exp_res.s);
        chk("exhausted", exhausted, exp_res.e);
        chk("timeout", timeout, exp_res.t);
      end
    end
    ready_q <= ready;
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic load(input logic [7:0] b);
    cfg_load = 1'b1;
    cfg_base_nonce = b;
    tick();
    cfg_load = 1'b0;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_launch(input int bound, output int cnt);
    cnt = 0;
    while (core_start !== 1'b1 && cnt < bound) begin
      tick();
      cnt++;
    end
  endtask
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (ready !== 1'b1 && cnt < 60) begin
      tick();
      cnt++;
    end
    chk("ready_seen", ready, 1);
  endtask
  task automatic done(input logic [3:0] f);
    core_done = 1'b1;
    core_match_flags = f;
    tick();
    core_done = 1'b0;
    core_match_flags = '0;
  endtask
  task automatic ack();
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
  endtask
  task automatic push_res(input logic [7:0] nn, input logic [3:0] f, input logic s, input logic e, input logic t);
    res_t r;
    r.nonce = nn;
    r.flags = f;
    r.s = s;
    r.e = e;
    r.t = t;
    res_q.push_back(r);
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      cfg_load = 1'($urandom);
      cfg_base_nonce = 8'($urandom);
      start = 1'($urandom);
      abort = 1'($urandom);
      result_ack = 1'($urandom);
      core_done = 1'($urandom);
      core_match_flags = 4'($urandom);
      tick();
    end
    {cfg_load, start, abort, result_ack, core_done} = '0;
    core_match_flags = '0;
    reset = 1'b0;
    chk("rst_core_reset_n", core_reset_n, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_ready", ready, 0);
    chk("rst_status", {success, exhausted, timeout}, 0);
    chk("rst_base", core_nonce_base, 0);
    chk("rst_result", {result_nonce, result_flags}, 0);
    pulse_start();
    wait_launch(6, n);
    chk("idle_start_ignored", core_start, 0);
    chk("idle_core_reset_n", core_reset_n, 0);
    // match on the second pass
    load(8'h13);
    chk("armed_base", core_nonce_base, 8'h10);
    pass_q.push_back(8'h10);
    pulse_start();
    chk("launch_core_reset_n", core_reset_n, 1);
    wait_launch(10, n);
    chk("start_latency", n + 1, 2);
    pass_q.push_back(8'h14);
    done(4'b0000);
    chk("sweep_core_reset_n", core_reset_n, 1);
    wait_launch(10, n);
    chk("relaunch_latency", n + 1, 2);
    push_res(8'h14, 4'b0100, 1, 0, 0);
    done(4'b0100);
    wait_ready(n);
    chk("match_core_reset_n", core_reset_n, 0);
    cfg_load = 1'b1;
    cfg_base_nonce = 8'h99;
    start = 1'b1;
    tick();
    {cfg_load, start} = '0;
    repeat (3) tick();
    chk("done_hold_ready", ready, 1);
    chk("done_hold_nonce", result_nonce, 8'h14);
    chk("done_hold_base", core_nonce_base, 8'h14);
    ack();
    chk("ack_ready", ready, 0);
    chk("ack_status", {success, exhausted, timeout}, 0);
    chk("ack_flags", result_flags, 0);
    chk("ack_nonce_held", result_nonce, 8'h14);
    // exhaustion over the last two blocks
    load(8'hF8);
    pass_q.push_back(8'hF8);
    pulse_start();
    wait_launch(10, n);
    pass_q.push_back(8'hFC);
    done(4'b0000);
    wait_launch(10, n);
    push_res(8'hFC, 4'b0000, 0, 1, 0);
    done(4'b0000);
    wait_ready(n);
    chk("exh_core_reset_n", core_reset_n, 0);
    ack();
    // watchdog timeout
    load(8'h20);
    pass_q.push_back(8'h20);
    pulse_start();
    wait_launch(10, n);
    push_res(8'h20, 4'b0000, 0, 0, 1);
    wait_ready(n);
    chk("timeout_cycles", n, 16);
    ack();
    // abort beats a matching core_done
    load(8'h30);
    pass_q.push_back(8'h30);
    pulse_start();
    wait_launch(10, n);
    abort = 1'b1;
    done(4'b0001);
    abort = 1'b0;
    chk("abort_ready", ready, 0);
    chk("abort_success", success, 0);
    chk("abort_core_reset_n", core_reset_n, 0);
    pulse_start();
    wait_launch(6, n);
    chk("abort_idle", core_start, 0);
    // core_done in the expiry cycle beats the watchdog
    load(8'h50);
    pass_q.push_back(8'h50);
    pulse_start();
    wait_launch(10, n);
    repeat (15) tick();
    push_res(8'h50, 4'b1000, 1, 0, 0);
    done(4'b1000);
    wait_ready(n);
    ack();
    // fresh job after acknowledge
    load(8'h40);
    pass_q.push_back(8'h40);
    pulse_start();
    wait_launch(10, n);
    push_res(8'h40, 4'b0001, 1, 0, 0);
    done(4'b0001);
    wait_ready(n);
    ack();
    chk("final_ready", ready, 0);
    chk("final_nonce_held", result_nonce, 8'h40);
    repeat (2) tick();
    chk("pass_q_drained", pass_q.size(), 0);
    chk("res_q_drained", res_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
